// File: rtl/sram_request_frontend.sv
// sram_request_frontend: valid/ready request front-end for a single-port SRAM.
// Requests drive the SRAM pins combinationally. Read data returns one edge
// after acceptance and is buffered in an in-order response FIFO with full
// backpressure. The array can be zeroed row by row after reset.
module sram_request_frontend #(
  parameter int WIDTH          = 128,
  parameter int NUM_ROWS       = 4096,
  parameter int CLEAR_ON_RESET = 1,
  parameter int RSP_DEPTH      = 3,
  localparam int AW            = $clog2(NUM_ROWS)
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             init_done,
  output logic             sram_ceb,
  output logic             sram_web,
  output logic [AW-1:0]    sram_a,
  output logic [WIDTH-1:0] sram_d,
  output logic [WIDTH-1:0] sram_m,
  input  logic [WIDTH-1:0] sram_q
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] mem_q [RSP_DEPTH];

  logic [CW:0]      occ;
  logic             req_fire;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts buffered entries plus the read whose data is still in
  // the SRAM output register, so an accepted read always has a free slot.
  // rsp_ready is deliberately not part of this term.
  assign occ       = {1'b0, cnt_q} + (CW+1)'(inflight_q);
  assign req_ready = (state_q == ST_RUN) && (occ < (CW+1)'(RSP_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign init_done = (state_q == ST_RUN);

  assign push      = inflight_q;
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : '0;

  // Control state: FSM, clear counter, read tracking and FIFO pointers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q    <= ST_START;
      clr_addr_q <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Response storage is data only; validity is tracked by cnt_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_q;
    end
  end

  // Next-state logic and SRAM pin drive for the START/CLEAR/RUN sequence.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    sram_ceb   = 1'b0;
    sram_web   = 1'b0;
    sram_a     = '0;
    sram_d     = '0;
    sram_m     = '0;
    case (state_q)
      ST_START: begin
        state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = clr_addr_q;
        sram_m   = '1;
        if (clr_addr_q == AW'(NUM_ROWS - 1)) begin
          state_d    = ST_RUN;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      ST_RUN: begin
        sram_ceb = req_fire;
        sram_web = req_write;
        sram_a   = req_addr;
        sram_d   = req_data;
        sram_m   = req_mask;
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // Read tracking and FIFO bookkeeping; push and pop may share an edge.
  always_comb begin
    inflight_d = req_fire && !req_write;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_sram_request_frontend.sv
// Directed testbench for sram_request_frontend: one clearing instance with a
// small array and one instance without clear, each with a behavioural SRAM.
module tb_sram_request_frontend;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RSTB, req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_data, req_mask;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          init_done, sram_ceb, sram_web;
  logic [AW-1:0] sram_a;
  logic [W-1:0]  sram_d, sram_m, sram_q;

  logic          RSTB2, req_valid2, req_ready2, rsp_valid2, rsp_ready2;
  logic [W-1:0]  rsp_data2;
  logic          init_done2, sram_ceb2, sram_web2;
  logic [AW-1:0] sram_a2;
  logic [W-1:0]  sram_d2, sram_m2, sram_q2;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic model_ready = 1'b0;

  sram_request_frontend #(.WIDTH(W), .NUM_ROWS(N), .CLEAR_ON_RESET(1), .RSP_DEPTH(3)) dut (
    .CLK(CLK), .RSTB(RSTB), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .init_done(init_done),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_m(sram_m), .sram_q(sram_q));

  sram_request_frontend #(.WIDTH(W), .NUM_ROWS(N), .CLEAR_ON_RESET(0), .RSP_DEPTH(3)) dut_nc (
    .CLK(CLK), .RSTB(RSTB2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .init_done(init_done2),
    .sram_ceb(sram_ceb2), .sram_web(sram_web2), .sram_a(sram_a2), .sram_d(sram_d2),
    .sram_m(sram_m2), .sram_q(sram_q2));

  // Behavioural SRAMs: masked write, registered read, preloaded with a pattern.
  logic [W-1:0] mem  [N];
  logic [W-1:0] mem2 [N];

  always @(posedge CLK) begin
    if (!model_ready) begin
      for (int i = 0; i < N; i++) mem[i] <= 32'hDEAD0000 | i;
    end else if (sram_ceb) begin
      if (sram_web) mem[sram_a] <= (mem[sram_a] & ~sram_m) | (sram_d & sram_m);
      else          sram_q      <= mem[sram_a];
    end
  end

  always @(posedge CLK) begin
    if (!model_ready) begin
      for (int i = 0; i < N; i++) mem2[i] <= 32'hDEAD0000 | i;
    end else if (sram_ceb2) begin
      if (sram_web2) mem2[sram_a2] <= (mem2[sram_a2] & ~sram_m2) | (sram_d2 & sram_m2);
      else           sram_q2       <= mem2[sram_a2];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({req_ready, rsp_valid, init_done, sram_ceb} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b required 0000", {req_ready, rsp_valid, init_done, sram_ceb}); end
    n_cmp++; if (rsp_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
    n_cmp++; if ({sram_web, sram_a, sram_d, sram_m} !== '0) begin
      n_bad++; $display("FAIL reset_sram_pins: got %b %h %h %h required 0", sram_web, sram_a, sram_d, sram_m); end
  endtask

  task automatic test_clear();
    RSTB = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      n_cmp++; if ({sram_ceb, sram_web, sram_a, sram_d, sram_m, init_done} !== {1'b1, 1'b1, AW'(i), 32'h0, 32'hFFFFFFFF, 1'b0}) begin
        n_bad++; $display("FAIL clear_row%0d: got ceb=%b web=%b a=%0d d=%h m=%h done=%b required 1 1 %0d 0 ffffffff 0",
                          i, sram_ceb, sram_web, sram_a, sram_d, sram_m, init_done, i); end
      tick();
    end
    n_cmp++; if ({init_done, req_ready, sram_ceb} !== 3'b110) begin
      n_bad++; $display("FAIL clear_done: got %b required 110", {init_done, req_ready, sram_ceb}); end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    #1;
    n_cmp++; if (sram_ceb !== 1'b1) begin
      n_bad++; $display("FAIL read5_ceb: got %b required 1", sram_ceb); end
    tick();
    req_valid = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL read5_early: got %b required 0", rsp_valid); end
    tick();
    n_cmp++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL read5_data: got %b %h required 1 00000000", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_data = 32'hA5A55A5A; req_mask = '1;
    tick();
    req_write = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL wr_rd_ready: got %b required 1", req_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL wr_rd_early: got %b required 0", rsp_valid); end
    tick();
    n_cmp++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hA5A55A5A}) begin
      n_bad++; $display("FAIL wr_rd_data: got %b %h required 1 a5a55a5a", rsp_valid, rsp_data); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL wr_rd_pop: got %b required 0", rsp_valid); end
  endtask

  task automatic test_masked_write();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7; req_data = 32'hFFFF0000; req_mask = '1;
    tick();
    req_data = 32'h12345678; req_mask = 32'h0000FFFF;
    tick();
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    n_cmp++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hFFFF5678}) begin
      n_bad++; $display("FAIL masked_data: got %b %h required 1 ffff5678", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_backpressure();
    int acc;
    int got;
    logic fire;
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(i); req_data = i; req_mask = '1;
      tick();
    end
    req_write = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      req_addr = AW'(acc);
      #1;
      n_cmp++; if (req_ready !== (c < 3)) begin
        n_bad++; $display("FAIL bp_accept_c%0d: got ready=%b required %b", c, req_ready, (c < 3)); end
      if (req_ready) acc++;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if ({req_ready, rsp_valid, rsp_data} !== {1'b0, 1'b1, 32'h0}) begin
        n_bad++; $display("FAIL bp_hold_c%0d: got ready=%b valid=%b data=%h required 0 1 00000000", c, req_ready, rsp_valid, rsp_data); end
      tick();
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      req_valid = (acc < 10);
      req_addr  = AW'(acc);
      #1;
      if (rsp_valid) begin
        n_cmp++; if (rsp_data !== W'(got)) begin
          n_bad++; $display("FAIL bp_order%0d: got %h required %h", got, rsp_data, got); end
        got++;
      end else if (got > 0) begin
        n_cmp++; n_bad++;
        $display("FAIL bp_gap: got rsp_valid=0 after %0d responses required 1", got);
      end
      fire = req_valid && req_ready;
      tick();
      if (fire) acc++;
      if (got == 10) break;
    end
    req_valid = 1'b0;
    n_cmp++; if (got !== 10) begin
      n_bad++; $display("FAIL bp_count: got %0d responses required 10", got); end
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drained: got %b required 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_clear();
    RSTB = 1'b0;
    tick();
    RSTB = 1'b1;
    tick();
    repeat (7) tick();
    n_cmp++; if ({sram_ceb, sram_a} !== {1'b1, 4'd7}) begin
      n_bad++; $display("FAIL midclr_row7: got %b %0d required 1 7", sram_ceb, sram_a); end
    #2;
    RSTB = 1'b0;
    #1;
    n_cmp++; if ({req_ready, rsp_valid, init_done, sram_ceb, sram_web, sram_a} !== '0) begin
      n_bad++; $display("FAIL midclr_async: got %b required all 0", {req_ready, rsp_valid, init_done, sram_ceb, sram_web, sram_a}); end
    tick();
    tick();
    RSTB = 1'b1;
    tick();
    n_cmp++; if ({sram_ceb, sram_a} !== {1'b1, 4'd0}) begin
      n_bad++; $display("FAIL midclr_restart: got %b %0d required 1 0", sram_ceb, sram_a); end
    repeat (N) tick();
    n_cmp++; if (init_done !== 1'b1) begin
      n_bad++; $display("FAIL midclr_done: got %b required 1", init_done); end
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    tick();
    req_addr = 4'd4;
    tick();
    req_valid = 1'b0;
    #1;
    RSTB = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrd_async: got %b required 0", rsp_valid); end
    rsp_ready = 1'b1;
    seen = 1'b0;
    tick();
    RSTB = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midrd_discard: got rsp_valid seen=%b required 0", seen); end
    n_cmp++; if (init_done !== 1'b1) begin
      n_bad++; $display("FAIL midrd_done: got %b required 1", init_done); end
  endtask

  task automatic test_no_clear();
    #1;
    n_cmp++; if ({req_ready2, init_done2, sram_ceb2} !== 3'b000) begin
      n_bad++; $display("FAIL nc_reset: got %b required 000", {req_ready2, init_done2, sram_ceb2}); end
    RSTB2 = 1'b1;
    #1;
    n_cmp++; if (req_ready2 !== 1'b0) begin
      n_bad++; $display("FAIL nc_start: got %b required 0", req_ready2); end
    tick();
    n_cmp++; if ({req_ready2, init_done2, sram_ceb2} !== 3'b110) begin
      n_bad++; $display("FAIL nc_run: got %b required 110", {req_ready2, init_done2, sram_ceb2}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (sram_ceb2 !== 1'b0) begin
        n_bad++; $display("FAIL nc_idle%0d: got ceb=%b required 0", c, sram_ceb2); end
    end
    req_valid2 = 1'b1; req_write = 1'b0; req_addr = 4'd2;
    #1;
    n_cmp++; if (sram_ceb2 !== 1'b1) begin
      n_bad++; $display("FAIL nc_read_ceb: got %b required 1", sram_ceb2); end
    tick();
    req_valid2 = 1'b0;
    tick();
    n_cmp++; if ({rsp_valid2, rsp_data2} !== {1'b1, 32'hDEAD0002}) begin
      n_bad++; $display("FAIL nc_read_data: got %b %h required 1 dead0002", rsp_valid2, rsp_data2); end
    tick();
  endtask

  initial begin
    RSTB = 1'b0; RSTB2 = 1'b0;
    req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_data = '0; req_mask = '0;
    rsp_ready = 1'b1; rsp_ready2 = 1'b1;
    tick();
    tick();
    model_ready = 1'b1;
    test_reset();
    test_clear();
    test_write_read();
    test_masked_write();
    test_backpressure();
    test_reset_mid_clear();
    test_reset_mid_read();
    test_no_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
